// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with registered sync, blanking and pixel position
// Ports: clk (rising edge), reset (sync, active-low), en (pixel advance),
//        hsync/vsync (active-low sync), video_on (visible region),
//        pixel_x/pixel_y (presented position), frame_start (pulse at (0,0)).
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNCP, V_BACK} v_state_t;
  logic [9:0] r_h_cnt, r_v_cnt;
  h_state_t   r_h_st, w_h_nxt;
  v_state_t   r_v_st, w_v_nxt;
  logic       w_h_wrap, w_v_wrap;
  assign w_h_wrap = r_h_cnt == 10'(H_TOTAL - 1);
  assign w_v_wrap = r_v_cnt == 10'(V_TOTAL - 1);
  // Each state leaves on the last count of its region, so the state always
  // describes the counter value it sits beside.
  always_comb begin
    w_h_nxt = r_h_st;
    case (r_h_st)
      H_ACTIVE: if (r_h_cnt == 10'(H_VISIBLE - 1)) w_h_nxt = H_FRONT;
      H_FRONT:  if (r_h_cnt == 10'(H_VISIBLE + H_FP - 1)) w_h_nxt = H_SYNCP;
      H_SYNCP:  if (r_h_cnt == 10'(H_VISIBLE + H_FP + H_SYNC - 1)) w_h_nxt = H_BACK;
      H_BACK:   if (w_h_wrap) w_h_nxt = H_ACTIVE;
      default:  w_h_nxt = H_ACTIVE;
    endcase
  end
  // Vertical transitions happen only at the end of a line.
  always_comb begin
    w_v_nxt = r_v_st;
    case (r_v_st)
      V_ACTIVE: if (w_h_wrap && r_v_cnt == 10'(V_VISIBLE - 1)) w_v_nxt = V_FRONT;
      V_FRONT:  if (w_h_wrap && r_v_cnt == 10'(V_VISIBLE + V_FP - 1)) w_v_nxt = V_SYNCP;
      V_SYNCP:  if (w_h_wrap && r_v_cnt == 10'(V_VISIBLE + V_FP + V_SYNC - 1)) w_v_nxt = V_BACK;
      V_BACK:   if (w_h_wrap && w_v_wrap) w_v_nxt = V_ACTIVE;
      default:  w_v_nxt = V_ACTIVE;
    endcase
  end
  // Outputs are loaded from the current counter/state, one enabled cycle behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_h_st      <= H_ACTIVE;
      r_v_st      <= V_ACTIVE;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      r_h_cnt     <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
      r_v_cnt     <= w_h_wrap ? (w_v_wrap ? '0 : r_v_cnt + 10'd1) : r_v_cnt;
      r_h_st      <= w_h_nxt;
      r_v_st      <= w_v_nxt;
      hsync       <= r_h_st != H_SYNCP;
      vsync       <= r_v_st != V_SYNCP;
      video_on    <= r_h_st == H_ACTIVE && r_v_st == V_ACTIVE;
      pixel_x     <= r_h_cnt;
      pixel_y     <= r_v_cnt;
      frame_start <= r_h_cnt == '0 && r_v_cnt == '0;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed self-checking bench for vga_sync_gen on a reduced raster
module tb_vga_sync_gen;
  localparam int HV = 20, HF = 3, HS = 5, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam logic [23:0] RST_OUT = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};
  logic clk = 1'b0, reset = 1'b0, en = 1'b1;
  logic hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [23:0] obs;
  int vectors = 0, miscompares = 0;
  int cx = 0, cy = 0, px = 0, py = 0;
  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  assign obs = {hsync, vsync, video_on, pixel_x, pixel_y, frame_start};
  function automatic logic [23:0] exp_out(int x, int y);
    logic hs, vs, vo, fs;
    hs = !(x >= HV + HF && x < HV + HF + HS);
    vs = !(y >= VV + VF && y < VV + VF + VS);
    vo = x < HV && y < VV;
    fs = x == 0 && y == 0;
    return {hs, vs, vo, 10'(x), 10'(y), fs};
  endfunction
  task automatic tick;
    @(posedge clk);
    if (!reset) begin
      cx = 0;
      cy = 0;
    end else if (en) begin
      px = cx;
      py = cy;
      cx = cx + 1;
      if (cx == HT) begin
        cx = 0;
        cy = (cy == VT - 1) ? 0 : cy + 1;
      end
    end
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (obs !== RST_OUT) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, RST_OUT);
      end
    end
  endtask
  task automatic test_release;
    reset = 1'b1;
    tick;
    vectors++;
    if (obs !== exp_out(0, 0)) begin
      miscompares++;
      $display("FAIL release_first got=%h want=%h", obs, exp_out(0, 0));
    end
    tick;
    vectors++;
    if (obs !== exp_out(1, 0)) begin
      miscompares++;
      $display("FAIL release_second got=%h want=%h", obs, exp_out(1, 0));
    end
  endtask
  task automatic test_line;
    int lows = 0;
    for (int i = 0; i < HT - 1; i++) begin
      tick;
      vectors++;
      if (obs !== exp_out(px, py)) begin
        miscompares++;
        $display("FAIL line x=%0d y=%0d got=%h want=%h", px, py, obs, exp_out(px, py));
      end
      if (py == 0 && !hsync) lows++;
    end
    vectors++;
    if (lows != HS) begin
      miscompares++;
      $display("FAIL hsync_width got=%0d want=%0d", lows, HS);
    end
    vectors++;
    if ({pixel_x, pixel_y} !== {10'd0, 10'd1}) begin
      miscompares++;
      $display("FAIL line_wrap got=(%0d,%0d) want=(0,1)", pixel_x, pixel_y);
    end
  endtask
  task automatic test_frame;
    int lows = 0, starts = 0;
    for (int i = 0; i < HT * VT - HT; i++) begin
      tick;
      vectors++;
      if (obs !== exp_out(px, py)) begin
        miscompares++;
        $display("FAIL frame x=%0d y=%0d got=%h want=%h", px, py, obs, exp_out(px, py));
      end
      if (!vsync) lows++;
    end
    vectors++;
    if (lows != VS * HT) begin
      miscompares++;
      $display("FAIL vsync_width got=%0d want=%0d", lows, VS * HT);
    end
    vectors++;
    if ({pixel_x, pixel_y, frame_start} !== {10'd0, 10'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL frame_wrap got=(%0d,%0d,fs=%0b) want=(0,0,fs=1)", pixel_x, pixel_y, frame_start);
    end
    for (int i = 0; i < HT * VT; i++) begin
      tick;
      if (frame_start) starts++;
    end
    vectors++;
    if (starts != 1 || !frame_start || obs !== exp_out(0, 0)) begin
      miscompares++;
      $display("FAIL frame_period starts=%0d got=%h want one start ending at %h", starts, obs, exp_out(0, 0));
    end
  endtask
  task automatic test_enable;
    logic [23:0] want [4];
    logic        ens  [4];
    en = 1'b1;
    for (int i = 0; i < HT * VT - 1; i++) tick;
    vectors++;
    if (obs !== exp_out(HT - 1, VT - 1)) begin
      miscompares++;
      $display("FAIL enable_setup got=%h want=%h", obs, exp_out(HT - 1, VT - 1));
    end
    ens  = '{1'b1, 1'b0, 1'b0, 1'b1};
    want = '{exp_out(0, 0), exp_out(0, 0), exp_out(0, 0), exp_out(1, 0)};
    for (int i = 0; i < 4; i++) begin
      en = ens[i];
      tick;
      vectors++;
      if (obs !== want[i]) begin
        miscompares++;
        $display("FAIL enable_step%0d en=%0b got=%h want=%h", i, ens[i], obs, want[i]);
      end
    end
    en = 1'b1;
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 3 * HT + 24; i++) tick;
    vectors++;
    if (obs !== exp_out(25, 3) || hsync !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_setup got=%h want=%h", obs, exp_out(25, 3));
    end
    reset = 1'b0;
    tick;
    vectors++;
    if (obs !== RST_OUT) begin
      miscompares++;
      $display("FAIL mid_reset got=%h want=%h", obs, RST_OUT);
    end
    reset = 1'b1;
    tick;
    vectors++;
    if (obs !== exp_out(0, 0)) begin
      miscompares++;
      $display("FAIL mid_restart0 got=%h want=%h", obs, exp_out(0, 0));
    end
    tick;
    vectors++;
    if (obs !== exp_out(1, 0)) begin
      miscompares++;
      $display("FAIL mid_restart1 got=%h want=%h", obs, exp_out(1, 0));
    end
  endtask
  initial begin
    test_reset;
    test_release;
    test_line;
    test_frame;
    test_enable;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
